// File: rtl/romulus_ise_pipe.sv
// romulus_ise_pipe: two-stage issue/retire wrapper for the Romulus (SKINNY-128)
// ISE datapath. S1 decodes and drives the combinational datapath; S2 captures
// the result for writeback.
// Optional build macro ROMULUS_ISE_SKID_EN adds a 1-entry skid register in
// front of S1 so that in_ready is driven straight from a flop.
module romulus_ise_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_insn,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic [31:0] ise_rs1,
  output logic [31:0] ise_rs2,
  output logic [2:0]  ise_imm,
  output logic        op_rstep,
  output logic        op_rc_upd,
  output logic        op_tk_upd_0,
  output logic        op_tk_upd_1,
  output logic        op_rc_use_0,
  output logic        op_rc_use_1,
  input  logic [31:0] ise_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rd,
  output logic [4:0]  out_rd_addr,
  output logic        out_illegal
);

  // One decoded instruction as held in S1 (and in the skid, when present).
  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  op;       // one-hot, all-zero when illegal
    logic [2:0]  imm;
    logic [4:0]  rd_addr;
    logic        illegal;
  } s1_ent_t;

  function automatic s1_ent_t decode(input logic [31:0] insn,
                                     input logic [31:0] rs1,
                                     input logic [31:0] rs2);
    s1_ent_t e;
    logic    legal;
    legal     = (insn[6:0] == 7'b0101011) && (insn[14:12] == 3'b000) &&
                (insn[31:28] <= 4'h5);
    e.rs1     = rs1;
    e.rs2     = rs2;
    e.op      = legal ? (6'b000001 << insn[31:28]) : 6'b000000;
    e.imm     = insn[27:25];
    e.rd_addr = insn[11:7];
    e.illegal = !legal;
    return e;
  endfunction

  // Register-index fields are meaningless here: operand values arrive pre-read.
  logic unused_insn_bits;
  assign unused_insn_bits = ^in_insn[24:15];

  s1_ent_t     dec;
  s1_ent_t     s1_q, s1_d;
  logic        s1_valid_q, s1_valid_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_rd_q, out_rd_d;
  logic [4:0]  out_rd_addr_q, out_rd_addr_d;
  logic        out_illegal_q, out_illegal_d;
  logic        s2_free, s1_adv, s1_can_load, accept;

`ifdef ROMULUS_ISE_SKID_EN
  s1_ent_t     skid_q, skid_d;
  logic        skid_valid_q, skid_valid_d;
`endif

  // Handshake, S1 load selection and S2 capture.
  always_comb begin
    dec         = decode(in_insn, in_rs1, in_rs2);
    s2_free     = !out_valid_q || out_ready;
    s1_adv      = s1_valid_q && s2_free;
    s1_can_load = !s1_valid_q || s1_adv;
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q && !s1_adv;
`ifdef ROMULUS_ISE_SKID_EN
    in_ready     = !skid_valid_q;
    accept       = in_valid && in_ready;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    // The skid is older than anything on the input, so it wins the S1 slot.
    if (s1_can_load && skid_valid_q) begin
      s1_d         = skid_q;
      s1_valid_d   = 1'b1;
      skid_valid_d = 1'b0;
    end else if (s1_can_load && accept) begin
      s1_d       = dec;
      s1_valid_d = 1'b1;
    end
    // accept implies the skid is empty, so this never overwrites a live entry.
    if (accept && !s1_can_load) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
`else
    in_ready = !s1_valid_q || s2_free;
    accept   = in_valid && in_ready;
    if (accept) begin
      s1_d       = dec;
      s1_valid_d = 1'b1;
    end
`endif
    out_valid_d   = s1_adv || (out_valid_q && !out_ready);
    out_rd_d      = out_rd_q;
    out_rd_addr_d = out_rd_addr_q;
    out_illegal_d = out_illegal_q;
    if (s1_adv) begin
      out_rd_d      = s1_q.illegal ? 32'h0 : ise_rd;
      out_rd_addr_d = s1_q.rd_addr;
      out_illegal_d = s1_q.illegal;
    end
  end

  // Pipeline state; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q          <= '0;
      s1_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_rd_q      <= 32'h0;
      out_rd_addr_q <= 5'h0;
      out_illegal_q <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s1_valid_q    <= s1_valid_d;
      out_valid_q   <= out_valid_d;
      out_rd_q      <= out_rd_d;
      out_rd_addr_q <= out_rd_addr_d;
      out_illegal_q <= out_illegal_d;
    end
  end

`ifdef ROMULUS_ISE_SKID_EN
  // Skid entry in front of S1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`endif

  assign ise_rs1     = s1_q.rs1;
  assign ise_rs2     = s1_q.rs2;
  assign ise_imm     = s1_q.imm;
  assign op_rstep    = s1_q.op[0] && s1_valid_q;
  assign op_rc_upd   = s1_q.op[1] && s1_valid_q;
  assign op_tk_upd_0 = s1_q.op[2] && s1_valid_q;
  assign op_tk_upd_1 = s1_q.op[3] && s1_valid_q;
  assign op_rc_use_0 = s1_q.op[4] && s1_valid_q;
  assign op_rc_use_1 = s1_q.op[5] && s1_valid_q;
  assign out_valid   = out_valid_q;
  assign out_rd      = out_rd_q;
  assign out_rd_addr = out_rd_addr_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_romulus_ise_pipe.sv
// Bench for romulus_ise_pipe: stand-in combinational datapath, queue-based
// reference model of the pipeline, directed and random stimulus.
module tb_romulus_ise_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_insn, in_rs1, in_rs2, ise_rs1, ise_rs2, ise_rd, out_rd;
  logic [2:0]  ise_imm;
  logic [4:0]  out_rd_addr;
  logic        op_rstep, op_rc_upd, op_tk_upd_0, op_tk_upd_1, op_rc_use_0, op_rc_use_1;
  logic [5:0]  ops;

  int checks = 0, failures = 0;
  int nacc = 0, ndone = 0;
  bit no_op_expected = 0;

`ifdef ROMULUS_ISE_SKID_EN
  localparam int BP_ACC = 3;
`else
  localparam int BP_ACC = 2;
`endif

  typedef struct { logic [31:0] rd; logic [4:0] addr; logic ill; } exp_t;
  exp_t q[$];

  bit          hold_prev = 0;
  logic [31:0] prev_rd;
  logic [4:0]  prev_addr;
  logic        prev_ill;

  romulus_ise_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .ise_rs1(ise_rs1), .ise_rs2(ise_rs2), .ise_imm(ise_imm),
    .op_rstep(op_rstep), .op_rc_upd(op_rc_upd), .op_tk_upd_0(op_tk_upd_0),
    .op_tk_upd_1(op_tk_upd_1), .op_rc_use_0(op_rc_use_0), .op_rc_use_1(op_rc_use_1),
    .ise_rd(ise_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rd_addr(out_rd_addr), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  assign ops = {op_rc_use_1, op_rc_use_0, op_tk_upd_1, op_tk_upd_0, op_rc_upd, op_rstep};

  // Stand-in datapath behaviour per op index.
  function automatic logic [31:0] dp(input int k, input logic [31:0] a,
                                     input logic [31:0] b, input logic [2:0] imm);
    case (k)
      0:       return (a ^ {b[7:0], b[31:8]}) + 32'(imm);
      1:       return {26'h0, a[4:0], a[5] ^ a[4]};
      2:       return a + b + 32'(imm);
      3:       return a - b;
      4:       return a ^ b;
      default: return (a & ~b) | 32'(imm);
    endcase
  endfunction

  // Datapath reacts only to a strobe; otherwise it shows junk.
  always_comb begin
    ise_rd = 32'hDEADBEEF;
    if      (op_rstep)    ise_rd = dp(0, ise_rs1, ise_rs2, ise_imm);
    else if (op_rc_upd)   ise_rd = dp(1, ise_rs1, ise_rs2, ise_imm);
    else if (op_tk_upd_0) ise_rd = dp(2, ise_rs1, ise_rs2, ise_imm);
    else if (op_tk_upd_1) ise_rd = dp(3, ise_rs1, ise_rs2, ise_imm);
    else if (op_rc_use_0) ise_rd = dp(4, ise_rs1, ise_rs2, ise_imm);
    else if (op_rc_use_1) ise_rd = dp(5, ise_rs1, ise_rs2, ise_imm);
  end

  // Reference: what the wrapper must eventually retire for one instruction.
  function automatic exp_t model(input logic [31:0] insn, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    bit   legal;
    legal  = insn[6:0] == 7'h2B && insn[14:12] == 3'd0 && insn[31:28] <= 4'd5;
    e.rd   = legal ? dp(int'(insn[31:28]), a, b, insn[27:25]) : 32'h0;
    e.addr = insn[11:7];
    e.ill  = !legal;
    return e;
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] f, input logic [2:0] imm,
                                     input logic [4:0] rd, input logic [2:0] f3,
                                     input logic [6:0] opc);
    logic [31:0] r;
    r = $urandom;
    return {f, imm, r[9:0], f3, rd, opc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic offer(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_insn = insn; in_rs1 = a; in_rs2 = b;
  endtask

  // One clock: sample at negedge (handshakes that the coming edge will take),
  // then return 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    chk("op_onehot", 32'($countones(ops) <= 1), 32'd1);
    if (no_op_expected) chk("illegal_no_op", 32'(ops), 32'd0);
    if (hold_prev) begin
      chk("stable_valid", 32'(out_valid), 32'd1);
      chk("stable_rd", out_rd, prev_rd);
      chk("stable_addr", 32'(out_rd_addr), 32'(prev_addr));
      chk("stable_ill", 32'(out_illegal), 32'(prev_ill));
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_result", 32'(out_valid), 32'd0);
      else begin
        e = q.pop_front();
        chk("res_rd", out_rd, e.rd);
        chk("res_addr", 32'(out_rd_addr), 32'(e.addr));
        chk("res_ill", 32'(out_illegal), 32'(e.ill));
        ndone++;
      end
    end
    hold_prev = out_valid && !out_ready;
    prev_rd = out_rd; prev_addr = out_rd_addr; prev_ill = out_illegal;
    if (in_valid && in_ready) begin
      q.push_back(model(in_insn, in_rs1, in_rs2));
      nacc++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, k, guard;
    logic [31:0] bp_insn[3];
    logic [31:0] r;

    // ---- reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_insn = '0; in_rs1 = '0; in_rs2 = '0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ops", 32'(ops), 32'd0);
    chk("rst_out_rd", out_rd, 32'd0);
    chk("rst_out_addr", 32'(out_rd_addr), 32'd0);
    chk("rst_out_ill", 32'(out_illegal), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- rc_upd: single-cycle strobe, 2-edge latency
    out_ready = 1'b1;
    offer(mk(4'd1, 3'd0, 5'd3, 3'd0, 7'h2B), 32'h3F, $urandom);
    tick();
    in_valid = 1'b0;
    chk("rcupd_strobe", 32'(op_rc_upd), 32'd1);
    chk("rcupd_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("rcupd_strobe_gone", 32'(op_rc_upd), 32'd0);
    chk("rcupd_valid", 32'(out_valid), 32'd1);
    chk("rcupd_rd", out_rd, 32'h0000003E);
    chk("rcupd_ill", 32'(out_illegal), 32'd0);
    tick();

    // ---- back-to-back rc_use_0 x4
    for (int i = 0; i < 4; i++) begin
      offer(mk(4'd4, 3'(i), 5'(10 + i), 3'd0, 7'h2B), 32'h5, 32'hFFFFFFF0);
      tick();
      if (i >= 1) begin
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_rd", out_rd, 32'hFFFFFFF5);
        chk("b2b_addr", 32'(out_rd_addr), 32'(10 + i - 1));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_last_valid", 32'(out_valid), 32'd1);
    chk("b2b_last_addr", 32'(out_rd_addr), 32'd13);
    tick();
    chk("b2b_drained", 32'(out_valid), 32'd0);

    // ---- backpressure: 5 stalled cycles, 3 offered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) bp_insn[i] = mk(4'(i), 3'(i), 5'(20 + i), 3'd0, 7'h2B);
    k = 0;
    for (int c = 0; c < 5; c++) begin
      if (k < 3) offer(bp_insn[k], $urandom, $urandom); else in_valid = 1'b0;
      a0 = nacc;
      tick();
      if (nacc != a0) k++;
    end
    chk("bp_accepted", 32'(k), 32'(BP_ACC));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_frozen_addr", 32'(out_rd_addr), 32'd20);
    out_ready = 1'b1;
    guard = 0;
    while ((k < 3 || q.size() != 0) && guard < 30) begin
      if (k < 3) offer(bp_insn[k], $urandom, $urandom); else in_valid = 1'b0;
      a0 = nacc;
      tick();
      if (nacc != a0) k++;
      guard++;
    end
    chk("bp_drain_timeout", 32'(guard < 30), 32'd1);
    tick();
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // ---- illegal instructions
    no_op_expected = 1'b1;
    offer(mk(4'd0, 3'd1, 5'd5, 3'd0, 7'h33), $urandom, $urandom); tick();
    offer(mk(4'd2, 3'd2, 5'd6, 3'd1, 7'h2B), $urandom, $urandom); tick();
    offer(mk(4'd7, 3'd3, 5'd7, 3'd0, 7'h2B), $urandom, $urandom); tick();
    in_valid = 1'b0;
    chk("ill_out_ill", 32'(out_illegal), 32'd1);
    chk("ill_out_rd", out_rd, 32'd0);
    tick(); tick(); tick();
    no_op_expected = 1'b0;
    chk("ill_all_retired", 32'(q.size()), 32'd0);

    // ---- random traffic against the model
    for (int c = 0; c < 300; c++) begin
      r = $urandom;
      if (r[1:0] != 2'd0) begin
        offer(mk(4'(r[7:4] & 4'h7), 3'(r[10:8]), 5'(r[15:11]),
                 (r[19:16] == 4'd0) ? 3'd1 : 3'd0,
                 (r[23:20] == 4'd0) ? 7'h33 : 7'h2B), $urandom, $urandom);
      end else in_valid = 1'b0;
      out_ready = (r[26:24] != 3'd0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin tick(); guard++; end
    chk("rand_drained", 32'(q.size()), 32'd0);
    chk("rand_count", 32'(ndone), 32'(nacc));

    // ---- async reset with S1 and S2 both full
    out_ready = 1'b0;
    offer(mk(4'd3, 3'd1, 5'd8, 3'd0, 7'h2B), $urandom, $urandom); tick();
    offer(mk(4'd5, 3'd2, 5'd9, 3'd0, 7'h2B), $urandom, $urandom); tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_op", 32'(ops), 32'h20);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ops", 32'(ops), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    hold_prev = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
